// File: rtl/canvas_brush_painter_if.sv
// Mouse-in / canvas-RAM-write-out bundle for the brush painter.
// The painter is the master: it drives the write side and consumes the mouse side.
interface canvas_brush_painter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 1
);
  logic              mouse_left;
  logic              mouse_middle;
  logic              mouse_right;
  logic [9:0]        mouse_x;
  logic [9:0]        mouse_y;
  logic              write_enable;
  logic [ADDR_W-1:0] write_addr;
  logic [DATA_W-1:0] write_data;
  logic              busy;
  logic              clear_done;

  modport master (
    input  mouse_left, mouse_middle, mouse_right, mouse_x, mouse_y,
    output write_enable, write_addr, write_data, busy, clear_done
  );

  modport slave (
    output mouse_left, mouse_middle, mouse_right, mouse_x, mouse_y,
    input  write_enable, write_addr, write_data, busy, clear_done
  );
endinterface

// File: rtl/canvas_brush_painter.sv
// Mouse-driven canvas painter: clears the canvas RAM, then paints or erases a
// square (2R+1)^2 brush footprint around the pointer cell, one RAM write per cycle.
module canvas_brush_painter #(
  parameter int GRID_W     = 28,
  parameter int GRID_H     = 28,
  parameter int CELL_SHIFT = 4,
  parameter int X_ORIGIN   = 0,
  parameter int Y_ORIGIN   = 16,
  parameter int DATA_W     = 1,
  parameter int BRUSH_R    = 1,
  parameter int ADDR_W     = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  canvas_brush_painter_if.master bus
);

  // Offsets and cell coordinates are kept signed with headroom so that a brush
  // hanging over any grid edge can never alias onto a valid cell.
  localparam int unsigned SW    = 12;
  localparam int unsigned CELLS = GRID_W * GRID_H;

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_STROKE} state_t;

  state_t                state, next_state;
  logic [ADDR_W-1:0]     clr_cnt;
  logic signed [SW-1:0]  cx, cy, dx, dy;
  logic                  paint;

  logic signed [31:0]    rel_x, rel_y, tx, ty;
  logic                  in_bounds, in_grid, clr_last, stroke_last;
  logic [ADDR_W-1:0]     stroke_addr;

  logic                  write_enable_c, busy_c, clear_done_c;
  logic [ADDR_W-1:0]     write_addr_c;
  logic [DATA_W-1:0]     write_data_c;

  assign rel_x       = $signed({22'd0, bus.mouse_x}) - X_ORIGIN;
  assign rel_y       = $signed({22'd0, bus.mouse_y}) - Y_ORIGIN;
  assign in_bounds   = (rel_x >= 0) && (rel_x < (GRID_W << CELL_SHIFT)) &&
                       (rel_y >= 0) && (rel_y < (GRID_H << CELL_SHIFT));
  assign tx          = 32'(cx) + 32'(dx);
  assign ty          = 32'(cy) + 32'(dy);
  assign in_grid     = (tx >= 0) && (tx < GRID_W) && (ty >= 0) && (ty < GRID_H);
  assign stroke_addr = ADDR_W'(ty * GRID_W + tx);
  assign clr_last    = (clr_cnt == ADDR_W'(CELLS - 1));
  assign stroke_last = (dx == SW'(BRUSH_R)) && (dy == SW'(BRUSH_R));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_CLEAR;
    else     state <= next_state;
  end

  // Next-state: left > right > middle while idle
  always_comb begin
    next_state = state;
    case (state)
      S_CLEAR:  if (clr_last) next_state = S_IDLE;
      S_IDLE: begin
        if (bus.mouse_left) begin
          if (in_bounds) next_state = S_STROKE;
        end else if (bus.mouse_right) begin
          next_state = S_CLEAR;
        end else if (bus.mouse_middle && in_bounds) begin
          next_state = S_STROKE;
        end
      end
      S_STROKE: if (stroke_last) next_state = S_IDLE;
      default:  next_state = S_CLEAR;
    endcase
  end

  // Output decode for the current state/slot; registered below
  always_comb begin
    write_enable_c = 1'b0;
    write_addr_c   = '0;
    write_data_c   = '0;
    clear_done_c   = 1'b0;
    busy_c         = (state != S_IDLE);
    case (state)
      S_CLEAR: begin
        write_enable_c = 1'b1;
        write_addr_c   = clr_cnt;
        clear_done_c   = clr_last;
      end
      S_STROKE: begin
        if (in_grid) begin
          write_enable_c = 1'b1;
          write_addr_c   = stroke_addr;
          write_data_c   = {DATA_W{paint}};
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.write_enable <= 1'b0;
      bus.write_addr   <= '0;
      bus.write_data   <= '0;
      bus.clear_done   <= 1'b0;
      bus.busy         <= 1'b1;
    end else begin
      bus.write_enable <= write_enable_c;
      bus.write_addr   <= write_addr_c;
      bus.write_data   <= write_data_c;
      bus.clear_done   <= clear_done_c;
      bus.busy         <= busy_c;
    end
  end

  // Clear counter, brush offsets and stroke latch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clr_cnt <= '0;
      cx      <= '0;
      cy      <= '0;
      dx      <= SW'(-BRUSH_R);
      dy      <= SW'(-BRUSH_R);
      paint   <= 1'b0;
    end else begin
      case (state)
        S_CLEAR: clr_cnt <= clr_last ? '0 : clr_cnt + ADDR_W'(1);
        S_IDLE: begin
          clr_cnt <= '0;
          dx      <= SW'(-BRUSH_R);
          dy      <= SW'(-BRUSH_R);
          if (next_state == S_STROKE) begin
            cx    <= SW'(rel_x >>> CELL_SHIFT);
            cy    <= SW'(rel_y >>> CELL_SHIFT);
            paint <= bus.mouse_left;
          end
        end
        S_STROKE: begin
          if (dx == SW'(BRUSH_R)) begin
            dx <= SW'(-BRUSH_R);
            dy <= SW'(dy + 1);
          end else begin
            dx <= SW'(dx + 1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
